// File: rtl/cc_gate_pkg.sv
// Shared types and helpers for the cc channel-gating controller.
package cc_gate_pkg;

  localparam int CC_NCH_DEF    = 8;
  localparam int CC_HOLD_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_VALID = 2'd2
  } cc_state_e;

  // Per-channel capture mux: inhibit forces zero, otherwise mode picks override.
  function automatic logic capture_sel(input logic mode, input logic inhibit,
                                       input logic data, input logic ovr);
    capture_sel = inhibit ? 1'b0 : (mode ? ovr : data);
  endfunction

endpackage

// File: rtl/cc_holdoff_cnt.sv
// Loadable hold-off down-counter; saturates at zero instead of wrapping.
module cc_holdoff_cnt
  import cc_gate_pkg::*;
#(
  parameter int HOLD_W = CC_HOLD_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [HOLD_W-1:0] load_val_i,
  input  logic              dec_i,
  output logic              zero_o
);

  logic [HOLD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cc_gate_ctrl.sv
// Registered channel-gating controller: qualify, hold off, capture, then
// present the captured vector under a valid/ack handshake.
module cc_gate_ctrl
  import cc_gate_pkg::*;
#(
  parameter int NCH    = CC_NCH_DEF,
  parameter int HOLD_W = CC_HOLD_W_DEF
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic              sel_a_i,
  input  logic              sel_b_i,
  input  logic              mode_i,
  input  logic              inhibit_i,
  input  logic [HOLD_W-1:0] hold_cfg_i,
  input  logic [NCH-1:0]    data_in_i,
  input  logic [NCH-1:0]    ovr_in_i,
  input  logic              ack_i,
  output logic [NCH-1:0]    out_o,
  output logic              out_valid_o,
  output logic              busy_o,
  output logic              out_par_o
);

  cc_state_e      state_q;
  logic [NCH-1:0] out_q, cap_d;
  logic           valid_q, busy_q, par_q;
  logic           qual, cnt_load, cnt_dec, cnt_zero;

  assign qual = en_i & sel_a_i & sel_b_i;

  genvar g;
  for (g = 0; g < NCH; g++) begin : g_ch
    assign cap_d[g] = capture_sel(mode_i, inhibit_i, data_in_i[g], ovr_in_i[g]);
  end

  // Counter reloads on every entry into ARM, from IDLE or from an acked VALID.
  assign cnt_load = ((state_q == ST_IDLE) && qual) ||
                    ((state_q == ST_VALID) && en_i && ack_i && qual);
  assign cnt_dec  = (state_q == ST_ARM) && en_i;

  cc_holdoff_cnt #(.HOLD_W(HOLD_W)) u_cnt (
    .clk_i      (clock_i),
    .rst_i      (reset_i),
    .load_i     (cnt_load),
    .load_val_i (hold_cfg_i),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (qual) begin
            state_q <= ST_ARM;
            busy_q  <= 1'b1;
          end
        end
        ST_ARM: begin
          if (!en_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            out_q   <= '0;
            par_q   <= 1'b0;
            valid_q <= 1'b0;
          end else if (cnt_zero) begin
            state_q <= ST_VALID;
            out_q   <= cap_d;
            par_q   <= ^cap_d;
            valid_q <= 1'b1;
          end
        end
        ST_VALID: begin
          // en-low wins over a same-cycle ack and also clears the held vector.
          if (!en_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            out_q   <= '0;
            par_q   <= 1'b0;
            valid_q <= 1'b0;
          end else if (ack_i) begin
            valid_q <= 1'b0;
            if (qual) begin
              state_q <= ST_ARM;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign out_par_o   = par_q;

endmodule

// File: tb/tb_cc_gate_ctrl.sv
// Self-checking bench for cc_gate_ctrl (NCH=8 and NCH=1 builds side by side).
module tb_cc_gate_ctrl;

  localparam int HW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, sa, sb, mode, inh, ack;
  logic [HW-1:0] hold;
  logic [7:0]    din, ovr;
  logic [7:0]    out;
  logic          valid, busy, par;
  logic [0:0]    out1;
  logic          valid1, busy1, par1;

  int checks = 0;
  int failures = 0;

  cc_gate_ctrl #(.NCH(8), .HOLD_W(HW)) u_dut (
    .clock_i(clk), .reset_i(rst), .en_i(en), .sel_a_i(sa), .sel_b_i(sb),
    .mode_i(mode), .inhibit_i(inh), .hold_cfg_i(hold), .data_in_i(din),
    .ovr_in_i(ovr), .ack_i(ack), .out_o(out), .out_valid_o(valid),
    .busy_o(busy), .out_par_o(par)
  );

  cc_gate_ctrl #(.NCH(1), .HOLD_W(HW)) u_dut1 (
    .clock_i(clk), .reset_i(rst), .en_i(en), .sel_a_i(sa), .sel_b_i(sb),
    .mode_i(mode), .inhibit_i(inh), .hold_cfg_i(hold), .data_in_i(din[0]),
    .ovr_in_i(ovr[0]), .ack_i(ack), .out_o(out1), .out_valid_o(valid1),
    .busy_o(busy1), .out_par_o(par1)
  );

  // Reference model: a transaction is pending until an absolute capture cycle.
  bit         m_busy, m_wait, m_valid;
  logic [7:0] m_out;
  int         m_cap_at, cyc;

  task automatic model_step();
    logic q;
    q = en & sa & sb;
    if (rst) begin
      m_busy = 0; m_wait = 0; m_valid = 0; m_out = '0;
    end else if (m_busy && !en) begin
      m_busy = 0; m_wait = 0; m_valid = 0; m_out = '0;
    end else if (!m_busy) begin
      if (q) begin m_busy = 1; m_wait = 1; m_cap_at = cyc + 1 + int'(hold); end
    end else if (m_wait) begin
      if (cyc == m_cap_at) begin
        m_out = inh ? 8'h00 : (mode ? ovr : din);
        m_valid = 1; m_wait = 0;
      end
    end else if (ack) begin
      m_valid = 0;
      if (q) begin m_wait = 1; m_cap_at = cyc + 1 + int'(hold); end
      else m_busy = 0;
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; en = 1; sa = 0; sb = 0; mode = 0; inh = 0; ack = 0;
    hold = '0; din = '0; ovr = '0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; sa = 1; sb = 1; mode = 1; inh = 1; ack = 1;
    hold = '1; din = 8'hFF; ovr = 8'hFF;
    repeat (3) tick();
    checks++;
    if (out !== 8'h00 || valid !== 1'b0 || busy !== 1'b0 || par !== 1'b0) begin
      failures++;
      $display("FAIL reset: out=%h valid=%b busy=%b par=%b, want 00/0/0/0", out, valid, busy, par);
    end
    checks++;
    if (out1 !== 1'b0 || valid1 !== 1'b0 || busy1 !== 1'b0 || par1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_nch1: out=%b valid=%b busy=%b par=%b, want 0/0/0/0", out1, valid1, busy1, par1);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    hold = 4'd3; din = 8'hA5; sa = 1; sb = 1;
    tick();
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy: busy=%b valid=%b, want 1/0", busy, valid);
    end
    sa = 0;
    repeat (3) tick();
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early: valid=%b at t+4, want 0", valid);
    end
    tick();
    checks++;
    if (out !== 8'hA5 || valid !== 1'b1 || par !== 1'b0) begin
      failures++;
      $display("FAIL basic_capture: out=%h valid=%b par=%b, want a5/1/0", out, valid, par);
    end
    checks++;
    if (out1 !== 1'b1 || valid1 !== 1'b1 || par1 !== 1'b1) begin
      failures++;
      $display("FAIL basic_nch1: out=%b valid=%b par=%b, want 1/1/1", out1, valid1, par1);
    end
    din = 8'h00; mode = 1; ovr = 8'hFF;
    repeat (4) tick();
    checks++;
    if (out !== 8'hA5 || valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_hold: out=%h valid=%b, want a5/1", out, valid);
    end
    ack = 1;
    tick();
    ack = 0;
    checks++;
    if (valid !== 1'b0 || out !== 8'hA5 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_ack: valid=%b out=%h busy=%b, want 0/a5/0", valid, out, busy);
    end
  endtask

  task automatic test_override_inhibit();
    do_reset();
    hold = 4'd0; mode = 1; ovr = 8'h3C; din = 8'hC3; sa = 1; sb = 1;
    tick();
    sa = 0;
    tick();
    checks++;
    if (out !== 8'h3C || valid !== 1'b1 || par !== 1'b0) begin
      failures++;
      $display("FAIL override: out=%h valid=%b par=%b, want 3c/1/0", out, valid, par);
    end
    ack = 1;
    tick();
    ack = 0; sa = 1;
    tick();
    sa = 0; inh = 1;
    tick();
    inh = 0;
    checks++;
    if (out !== 8'h00 || valid !== 1'b1 || par !== 1'b0) begin
      failures++;
      $display("FAIL inhibit: out=%h valid=%b par=%b, want 00/1/0", out, valid, par);
    end
  endtask

  task automatic test_abort();
    int seen;
    do_reset();
    hold = 4'd5; din = 8'h77; sa = 1; sb = 1;
    tick();
    sa = 0;
    repeat (2) tick();
    en = 0;
    tick();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_arm: busy=%b valid=%b, want 0/0", busy, valid);
    end
    en = 1;
    seen = 0;
    repeat (8) begin tick(); if (valid) seen++; end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort_novalid: valid cycles=%0d, want 0", seen);
    end
    hold = 4'd0; din = 8'h81; sa = 1;
    tick();
    sa = 0;
    tick();
    en = 0; ack = 1;
    tick();
    en = 1; ack = 0;
    checks++;
    if (out !== 8'h00 || valid !== 1'b0 || par !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_valid: out=%h valid=%b par=%b busy=%b, want 00/0/0/0", out, valid, par, busy);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    hold = 4'd1; din = 8'h01; sa = 1; sb = 1;
    n = 0;
    while (!valid && n < 10) begin tick(); n++; end
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL b2b_first: latency=%0d, want 3", n);
    end
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (out !== 8'(k)) begin
        failures++;
        $display("FAIL b2b_data%0d: out=%h, want %h", k, out, 8'(k));
      end
      ack = 1; din = 8'(k + 1);
      tick();
      ack = 0;
      n = 1;
      while (!valid && n < 10) begin tick(); n++; end
      checks++;
      if (n !== 3) begin
        failures++;
        $display("FAIL b2b_gap%0d: cycles ack->valid=%0d, want 3", k, n);
      end
    end
    sa = 0;
  endtask

  task automatic test_max_hold();
    int n;
    do_reset();
    hold = 4'd15; din = 8'h5A; sa = 1; sb = 1;
    tick();
    sa = 0;
    n = 1;
    while (!valid && n < 40) begin tick(); n++; end
    checks++;
    if (n !== 17 || out !== 8'h5A) begin
      failures++;
      $display("FAIL max_hold: latency=%0d out=%h, want 17/5a", n, out);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    rst = 1; en = 1; sa = 0; sb = 0; ack = 0;
    cyc = 0;
    model_step();
    tick();
    for (int i = 0; i < 1500; i++) begin
      rst  = ($urandom_range(99) == 0);
      en   = ($urandom_range(15) != 0);
      sa   = $urandom_range(1);
      sb   = ($urandom_range(3) != 0);
      ack  = ($urandom_range(2) == 0);
      mode = $urandom_range(1);
      inh  = ($urandom_range(3) == 0);
      hold = ($urandom_range(3) == 0) ? HW'($urandom_range(15)) : HW'($urandom_range(2));
      din  = 8'($urandom);
      ovr  = 8'($urandom);
      model_step();
      tick();
      checks++;
      if (out !== m_out || valid !== m_valid || busy !== m_busy || par !== ^m_out) begin
        failures++;
        if (bad++ < 10)
          $display("FAIL random_c%0d: out=%h v=%b b=%b p=%b, want %h/%b/%b/%b",
                   i, out, valid, busy, par, m_out, m_valid, m_busy, ^m_out);
      end
      checks++;
      if (out1 !== m_out[0] || valid1 !== m_valid || busy1 !== m_busy || par1 !== m_out[0]) begin
        failures++;
        if (bad++ < 10)
          $display("FAIL random_nch1_c%0d: out=%b v=%b b=%b p=%b, want %b/%b/%b/%b",
                   i, out1, valid1, busy1, par1, m_out[0], m_valid, m_busy, m_out[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_override_inhibit();
    test_abort();
    test_back_to_back();
    test_max_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
